// File: rtl/block_config_latches.sv
// LUT configuration store: a MEM_SIZE-bit truth table loaded as one block on cclk, read out by addr.
// Optional macro CONFIG_READBACK_EN adds the config_out readback port.
module block_config_latches #(
  parameter int ADDR_BITS = 4,
  parameter int MEM_SIZE  = 2**ADDR_BITS
) (
  input  logic                 cclk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic [MEM_SIZE-1:0]  config_in,
  input  logic [ADDR_BITS-1:0] addr,
  output logic                 out,
  output logic                 cfg_valid
`ifdef CONFIG_READBACK_EN
  ,
  output logic [MEM_SIZE-1:0]  config_out
`endif
);

  // The LUT mux indexes the full table, so the table must exactly fill the address space.
  if (MEM_SIZE != 2**ADDR_BITS) begin : g_bad_size
    $error("block_config_latches: MEM_SIZE must equal 2**ADDR_BITS");
  end

  logic [MEM_SIZE-1:0] mem;
  logic                loaded;

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      loaded <= 1'b0;
    end else if (cen) begin
      mem    <= config_in;
      loaded <= 1'b1;
    end
  end

  // Lookup is purely combinational so a new load shows up right after its edge.
  assign out       = mem[addr];
  assign cfg_valid = loaded;

`ifdef CONFIG_READBACK_EN
  assign config_out = mem;
`endif

endmodule

// File: tb/tb_block_config_latches.sv
// Self-checking bench for block_config_latches; expected outputs queued at stimulus time, popped on sampling.
module tb_block_config_latches;

  localparam int ADDR_BITS = 4;
  localparam int MEM_SIZE  = 2**ADDR_BITS;

  logic                 cclk = 1'b0;
  logic                 rst_n;
  logic                 cen;
  logic [MEM_SIZE-1:0]  config_in;
  logic [ADDR_BITS-1:0] addr;
  logic                 out;
  logic                 cfg_valid;
`ifdef CONFIG_READBACK_EN
  logic [MEM_SIZE-1:0]  config_out;
`endif

  block_config_latches #(.ADDR_BITS(ADDR_BITS), .MEM_SIZE(MEM_SIZE)) dut (
    .cclk      (cclk),
    .rst_n     (rst_n),
    .cen       (cen),
    .config_in (config_in),
    .addr      (addr),
    .out       (out),
    .cfg_valid (cfg_valid)
`ifdef CONFIG_READBACK_EN
    ,
    .config_out(config_out)
`endif
  );

  always #100 cclk = ~cclk;

  int checks   = 0;
  int failures = 0;

  logic [MEM_SIZE-1:0] model_mem;
  logic                model_valid;
  logic [1:0]          exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One configuration edge; the model follows the block-load rule.
  task automatic tick(input logic c, input logic [MEM_SIZE-1:0] d);
    @(negedge cclk);
    cen       = c;
    config_in = d;
    @(posedge cclk);
    if (rst_n && c) begin
      model_mem   = d;
      model_valid = 1'b1;
    end
    #1;
  endtask

  task automatic probe(input string tag, input int a, input logic exp_out, input logic exp_valid);
    logic [1:0] e;
    exp_q.push_back({exp_out, exp_valid});
    addr = a[ADDR_BITS-1:0];
    #2;
    e = exp_q.pop_front();
    check($sformatf("%s_out[%0d]", tag, a), {31'd0, out}, {31'd0, e[1]});
    check($sformatf("%s_vld[%0d]", tag, a), {31'd0, cfg_valid}, {31'd0, e[0]});
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < MEM_SIZE; a++)
      probe(tag, a, model_mem[a], model_valid);
  endtask

  initial begin
    model_mem   = '0;
    model_valid = 1'b0;
    rst_n       = 1'b0;
    cen         = 1'b1;
    config_in   = '1;
    addr        = '0;

    // Reset held across edges with cen high: loads must be ignored.
    @(posedge cclk);
    @(posedge cclk);
    #1;
    for (int a = 0; a < MEM_SIZE; a++) probe("rst", a, 1'b0, 1'b0);
`ifdef CONFIG_READBACK_EN
    check("rb_rst", {16'd0, config_out}, 32'h0000);
`endif
    @(negedge cclk);
    rst_n = 1'b1;
    cen   = 1'b0;

    // AND4 table.
    tick(1'b1, 16'h8000);
    sweep("and4");
    probe("and4_hi", 15, 1'b1, 1'b1);
    probe("and4_lo", 14, 1'b0, 1'b1);

    // XOR4 parity, then cen low with all-ones data must hold.
    tick(1'b1, 16'h6996);
    for (int i = 0; i < 5; i++) tick(1'b0, 16'hFFFF);
    sweep("xor4");
    probe("xor4_a3", 3, 1'b0, 1'b1);
    probe("xor4_a7", 7, 1'b1, 1'b1);
    probe("xor4_a0", 0, 1'b0, 1'b1);

    // Asynchronous reset between edges.
    tick(1'b1, 16'hAAAA);
    probe("aaaa_a1", 1, 1'b1, 1'b1);
    #20;
    rst_n       = 1'b0;
    model_mem   = '0;
    model_valid = 1'b0;
    probe("async_a1", 1, 1'b0, 1'b0);
    sweep("async");
    @(negedge cclk);
    rst_n = 1'b1;
    cen   = 1'b0;
    tick(1'b0, 16'hFFFF);
    probe("noload_a5", 5, 1'b0, 1'b0);

    // Back-to-back reloads: last sampled image wins.
    tick(1'b1, 16'h0001);
    probe("b2b1_a0", 0, 1'b1, 1'b1);
    tick(1'b1, 16'hFFFE);
    probe("b2b2_a0", 0, 1'b0, 1'b1);
    probe("b2b2_a1", 1, 1'b1, 1'b1);
    sweep("b2b");

`ifdef CONFIG_READBACK_EN
    tick(1'b1, 16'h1234);
    check("rb_load", {16'd0, config_out}, 32'h1234);
    #20;
    rst_n = 1'b0;
    #1;
    check("rb_clr", {16'd0, config_out}, 32'h0000);
    @(negedge cclk);
    rst_n = 1'b1;
`endif

    if (exp_q.size() != 0) check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/block_config_latches.md
BLOCK_CONFIG_LATCHES -- requirements
Module: block_config_latches

Interface
- REQ-001: Parameter ADDR_BITS, default 4, LUT address width; SHALL be legal for values 1..6.
- REQ-002: Parameter MEM_SIZE, default 2**ADDR_BITS, number of stored configuration bits; SHALL equal 2**ADDR_BITS; any other value is unsupported.
- REQ-003: cclk  input  1  configuration clock; all state changes on rising edge.
- REQ-004: rst_n  input  1  reset; asynchronous, active-low.
- REQ-005: cen  input  1  configuration enable; high loads config_in on the next rising cclk.
- REQ-006: config_in  input  MEM_SIZE  full truth-table image, loaded as one block.
- REQ-007: addr  input  ADDR_BITS  lookup address (LUT inputs).
- REQ-008: out  output  1  stored bit selected by addr.
- REQ-009: cfg_valid  output  1  high once at least one block load has completed since reset.
- REQ-010: config_out  output  MEM_SIZE  stored image readback; present only with CONFIG_READBACK_EN (REQ-021).

Function
- REQ-011: Storage SHALL be MEM_SIZE edge-triggered bits, mem[MEM_SIZE-1:0].
- REQ-012: On rising cclk with cen=1, mem SHALL take config_in in full, bit i to mem[i], in the same edge; no partial or serial load.
- REQ-013: On rising cclk with cen=0, mem SHALL hold.
- REQ-014: out SHALL equal mem[addr], purely combinational from addr and mem; zero-cycle latency from addr change.
- REQ-015: A load SHALL be visible on out immediately after the loading edge; no extra pipeline stage.
- REQ-016: cfg_valid SHALL rise on the first loading edge after reset and stay high until the next reset; further loads leave it high.
- REQ-017: cen held high for consecutive edges SHALL reload each edge; the last sampled config_in wins.
- REQ-018: addr all-zeros SHALL select mem[0]; addr all-ones SHALL select mem[MEM_SIZE-1]; no wrap or out-of-range case exists.

Reset
- REQ-019: rst_n=0 SHALL immediately and asynchronously clear mem to all zeros and cfg_valid to 0, so out=0 for every addr.
- REQ-020: While rst_n=0, cen SHALL be ignored; reset asserted mid-load SHALL win; the first load occurs on the first rising cclk with cen=1 after rst_n deasserts.

Configuration
- REQ-021: Macro CONFIG_READBACK_EN: when defined, port config_out SHALL exist and equal mem combinationally, all zeros in reset; when undefined, config_out SHALL be absent and all other behaviour SHALL be identical.

Verification
- REQ-022: Reset with rst_n=0, then sweep addr 0..15 -> out=0 for all addr, cfg_valid=0.
- REQ-023: ADDR_BITS=4, cen=1, config_in=16'h8000 for one edge, sweep addr -> out=1 only at addr=15 (AND4), cfg_valid=1.
- REQ-024: Load 16'h6996, then cen=0 with config_in=16'hFFFF for 5 edges -> out still follows XOR4 parity (addr=3 -> 0, addr=7 -> 1).
- REQ-025: Load 16'hAAAA, then assert rst_n=0 between clock edges -> out=0 and cfg_valid=0 without waiting for cclk.
- REQ-026: cen=1 for two edges with 16'h0001 then 16'hFFFE -> addr=0 gives 0, addr=1 gives 1 after the second edge.
- REQ-027: With CONFIG_READBACK_EN, load 16'h1234 -> config_out=16'h1234; after reset -> 16'h0000.
